// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: serializer states and
// elaboration-time helpers for bit timing and frame length.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    function automatic int clog2_f(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // Rounded to nearest; the residual error is the static baud error.
    function automatic int clks_per_bit_f(input int clk_hz, input int baud, input int fast_sim);
        if (fast_sim != 0) return 1;
        return (clk_hz + baud / 2) / baud;
    endfunction

    function automatic int frame_cycles_f(input int clks_per_bit, input int stop_bits);
        return (9 + stop_bits) * clks_per_bit;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Producer-facing bus of the buffered transmitter: write side, FIFO status
// and the serial line.
interface uart_tx_fifo_if #(
    parameter int FifoDepth = 16
);
    logic                                     wr_en;
    logic [7:0]                               wr_data;
    logic                                     full;
    logic [uart_pkg::clog2_f(FifoDepth):0]    count;
    logic                                     overflow;
    logic                                     TxD;
    logic                                     busy;

    modport master (
        output wr_en, wr_data,
        input  full, count, overflow, TxD, busy
    );

    modport slave (
        input  wr_en, wr_data,
        output full, count, overflow, TxD, busy
    );
endinterface

// File: rtl/uart_byte_fifo.sv
// Single-clock show-ahead byte FIFO; pushes while full and pops while empty
// are ignored so callers may strobe freely.
module uart_byte_fifo
    import uart_pkg::*;
#(
    parameter int Depth = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [7:0]                 din,
    input  logic                       pop,
    output logic [7:0]                 dout,
    output logic [clog2_f(Depth):0]    count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = clog2_f(Depth);
    localparam int CW = AW + 1;

    logic [7:0]    mem [Depth];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(Depth));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1/8N2 transmitter: byte FIFO feeding an LSB-first serializer
// that chains frames with no idle gap while bytes remain queued.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int ClkFrequency = 24000000,
    parameter int Baud         = 115200,
    parameter int StopBits     = 2,
    parameter int FifoDepth    = 16,
    parameter int FastSim      = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    uart_tx_fifo_if.slave         bus
);
    localparam int CPB      = clks_per_bit_f(ClkFrequency, Baud, FastSim);
    localparam int STOP_LEN = StopBits * CPB;
    localparam int CW       = clog2_f(STOP_LEN) + 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(CPB - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(STOP_LEN - 1);

    tx_state_t                      state_q, state_d;
    logic [CW-1:0]                  cnt_q, cnt_d;
    logic [2:0]                     bit_q, bit_d;
    logic [7:0]                     shift_q, shift_d;
    logic                           txd_q, txd_d;
    logic                           overflow_q;
    logic                           pop;
    logic [7:0]                     head;
    logic [clog2_f(FifoDepth):0]    fifo_count;
    logic                           fifo_full;
    logic                           fifo_empty;

    uart_byte_fifo #(.Depth(FifoDepth)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.wr_en),
        .din   (bus.wr_data),
        .pop   (pop),
        .dout  (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.full     = fifo_full;
    assign bus.count    = fifo_count;
    assign bus.overflow = overflow_q;
    assign bus.TxD      = txd_q;
    assign bus.busy     = (state_q != IDLE) || !fifo_empty;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = head;
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) state_d = STOP;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STOP: begin
                if (cnt_q == STOP_LAST) begin
                    cnt_d = '0;
                    // Chain straight into the next start bit when data is waiting.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = head;
                        bit_d   = '0;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level is registered from the upcoming state so TxD never glitches.
        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[0];
            default: txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            txd_q      <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            txd_q      <= txd_d;
            overflow_q <= bus.wr_en && fifo_full;
        end
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three configurations (2 stop bits, 1 stop bit,
// one bit per clock) with a frame-decoding monitor checked against a byte queue.
module tb_uart_tx_fifo;
    import uart_pkg::*;

    logic clk = 1'b0;
    logic rst_a, rst_b, rst_c;
    int   errors = 0;
    int   checks = 0;
    logic [7:0] exp_q [3][$];

    always #5 clk = ~clk;

    uart_tx_fifo_if #(.FifoDepth(16)) ifa ();
    uart_tx_fifo_if #(.FifoDepth(16)) ifb ();
    uart_tx_fifo_if #(.FifoDepth(16)) ifc ();

    uart_tx_fifo #(.ClkFrequency(1000000), .Baud(100000), .StopBits(2),
                   .FifoDepth(16), .FastSim(0))
        dut_a (.clk(clk), .rst(rst_a), .bus(ifa));
    uart_tx_fifo #(.ClkFrequency(1000000), .Baud(100000), .StopBits(1),
                   .FifoDepth(16), .FastSim(0))
        dut_b (.clk(clk), .rst(rst_b), .bus(ifb));
    uart_tx_fifo #(.ClkFrequency(1000000), .Baud(100000), .StopBits(2),
                   .FifoDepth(16), .FastSim(1))
        dut_c (.clk(clk), .rst(rst_c), .bus(ifc));

    function automatic logic txd_of(input int k);
        case (k)
            0:       return ifa.TxD;
            1:       return ifb.TxD;
            default: return ifc.TxD;
        endcase
    endfunction

    function automatic logic rst_of(input int k);
        case (k)
            0:       return rst_a;
            1:       return rst_b;
            default: return rst_c;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got=%0h required=%0h", name, act, req);
        end
    endtask

    // Decodes whole frames off the line; a reset during a frame abandons it.
    task automatic monitor(input int k, input int cpb, input int sb);
        logic [7:0] data;
        logic [7:0] req;
        logic       lvl, first;
        bit         ok, aborted;
        forever begin
            @(negedge clk);
            if (!rst_of(k) && txd_of(k) === 1'b0) begin
                ok = 1; aborted = 0; data = '0; first = 1'b0;
                for (int b = 0; b < 9 + sb && !aborted; b++) begin
                    for (int c = 0; c < cpb && !aborted; c++) begin
                        if (b != 0 || c != 0) @(negedge clk);
                        if (rst_of(k)) begin
                            aborted = 1;
                        end else begin
                            lvl = txd_of(k);
                            if (c == 0) first = lvl;
                            else if (lvl !== first) ok = 0;
                            if (b == 0 && lvl !== 1'b0) ok = 0;
                            if (b >= 9 && lvl !== 1'b1) ok = 0;
                            if (b >= 1 && b <= 8 && c == 0) data[b-1] = lvl;
                        end
                    end
                end
                if (!aborted) begin
                    checks++;
                    if (exp_q[k].size() == 0) begin
                        errors++;
                        $display("FAIL frame_dut%0d: got byte=%02h required=no frame", k, data);
                    end else begin
                        req = exp_q[k].pop_front();
                        if (data !== req || !ok) begin
                            errors++;
                            $display("FAIL frame_dut%0d: got byte=%02h shape_ok=%0d required byte=%02h shape_ok=1",
                                     k, data, ok, req);
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        fork
            monitor(0, 10, 2);
            monitor(1, 10, 1);
            monitor(2, 1, 2);
        join_none
    end

    initial begin
        int t;
        int lows;
        logic busy_last;
        logic [10:0] fast_seq;

        ifa.wr_en = 0; ifa.wr_data = '0;
        ifb.wr_en = 0; ifb.wr_data = '0;
        ifc.wr_en = 0; ifc.wr_data = '0;
        rst_a = 1; rst_b = 1; rst_c = 1;
        tick(); tick();
        rst_a = 0; rst_b = 0; rst_c = 0;

        // Reset state
        chk("reset_txd", ifa.TxD, 1);
        chk("reset_full", ifa.full, 0);
        chk("reset_count", ifa.count, 0);
        chk("reset_overflow", ifa.overflow, 0);
        chk("reset_busy", ifa.busy, 0);
        tick(); tick();

        // Single byte 0x55: start at N+2, busy falls at N+112
        ifa.wr_en = 1; ifa.wr_data = 8'h55; exp_q[0].push_back(8'h55);
        tick();
        ifa.wr_en = 0; ifa.wr_data = 8'hxx;
        chk("lat_count_n1", ifa.count, 1);
        chk("lat_busy_n1", ifa.busy, 1);
        tick();
        chk("lat_start_n2", ifa.TxD, 0);
        chk("lat_count_n2", ifa.count, 0);
        t = 2;
        while (ifa.busy && t < 400) begin tick(); t++; end
        chk("busy_fall_0x55", t, 112);
        tick(); tick();

        // Back-to-back 0xA3, 0x0F: second start exactly 110 cycles after first
        ifa.wr_en = 1; ifa.wr_data = 8'hA3; exp_q[0].push_back(8'hA3);
        tick();
        ifa.wr_data = 8'h0F; exp_q[0].push_back(8'h0F);
        tick();
        ifa.wr_en = 0;
        chk("b2b_first_start", ifa.TxD, 0);
        repeat (109) tick();
        chk("b2b_last_stop", ifa.TxD, 1);
        tick();
        chk("b2b_second_start", ifa.TxD, 0);
        t = 112;
        while (ifa.busy && t < 600) begin tick(); t++; end
        chk("b2b_busy_fall", t, 222);
        tick(); tick();

        // 18 consecutive writes: 17 accepted, 18th dropped with overflow pulse
        for (int i = 0; i < 18; i++) begin
            ifa.wr_en = 1; ifa.wr_data = 8'h30 + 8'(i);
            if (i < 17) exp_q[0].push_back(8'h30 + 8'(i));
            if (i == 17) begin
                chk("burst_count_c17", ifa.count, 16);
                chk("burst_full_c17", ifa.full, 1);
                chk("burst_ovf_c17", ifa.overflow, 0);
            end
            tick();
        end
        ifa.wr_en = 0;
        chk("burst_ovf_c18", ifa.overflow, 1);
        chk("burst_count_c18", ifa.count, 16);
        tick();
        chk("burst_ovf_c19", ifa.overflow, 0);
        t = 0;
        while (ifa.busy && t < frame_cycles_f(10, 2) * 18) begin tick(); t++; end
        chk("burst_drained", ifa.busy, 0);
        tick(); tick();

        // Reset during data bit 3 with 4 bytes queued
        for (int i = 0; i < 5; i++) begin
            ifa.wr_en = 1; ifa.wr_data = 8'hC0 + 8'(i);
            tick();
        end
        ifa.wr_en = 0;
        repeat (40) tick();
        chk("midreset_count_before", ifa.count, 4);
        rst_a = 1;
        tick();
        rst_a = 0;
        chk("midreset_txd", ifa.TxD, 1);
        chk("midreset_count", ifa.count, 0);
        chk("midreset_busy", ifa.busy, 0);
        lows = 0;
        repeat (200) begin
            if (ifa.TxD !== 1'b1) lows++;
            tick();
        end
        chk("midreset_no_frames", lows, 0);

        // StopBits=1, 0xFF: 100-cycle frame, low only for the start bit
        ifb.wr_en = 1; ifb.wr_data = 8'hFF; exp_q[1].push_back(8'hFF);
        tick();
        ifb.wr_en = 0;
        tick();
        chk("sb1_start", ifb.TxD, 0);
        lows = 0; busy_last = 1'b0;
        for (int j = 0; j < 100; j++) begin
            if (ifb.TxD === 1'b0) lows++;
            busy_last = ifb.busy;
            tick();
        end
        chk("sb1_low_cycles", lows, 10);
        chk("sb1_busy_cycle99", busy_last, 1);
        chk("sb1_busy_cycle100", ifb.busy, 0);

        // FastSim, 0x81: one bit per clock from N+2
        fast_seq = 11'b111_0000_0010;
        ifc.wr_en = 1; ifc.wr_data = 8'h81; exp_q[2].push_back(8'h81);
        tick();
        ifc.wr_en = 0;
        tick();
        for (int j = 0; j < 11; j++) begin
            chk($sformatf("fast_bit%0d", j), ifc.TxD, fast_seq[j]);
            tick();
        end
        chk("fast_idle_txd", ifc.TxD, 1);
        chk("fast_idle_busy", ifc.busy, 0);

        repeat (5) tick();
        for (int k = 0; k < 3; k++)
            chk($sformatf("queue_empty_dut%0d", k), exp_q[k].size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
